// File: rtl/limd_mc_pipe.sv
// Multi-channel pipelined a1 limiter: clamps A1T to +/-(A1_BOUND - A2P), tags results by channel,
// and keeps per-channel saturating counters of clamp events for the controller.
module limd_mc_pipe #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 32,
   parameter int CH_W     = 5,
   parameter int A1_BOUND = 15360,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CH_W-1:0]  in_ch,
   input  logic             in_bypass,
   input  logic [WIDTH-1:0] a1t,
   input  logic [WIDTH-1:0] a2p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH_W-1:0]  out_ch,
   output logic [WIDTH-1:0] a1p,
   output logic             out_sat,
   input  logic [CH_W-1:0]  stat_ch,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_cnt
);
   localparam int XW = WIDTH + 2;
   localparam logic signed [XW-1:0] BOUND_X = XW'(A1_BOUND);

   logic                    w_adv;
   logic signed [XW-1:0]    w_a1t_x;
   logic signed [XW-1:0]    w_a2p_x;
   logic signed [XW-1:0]    w_a1ul;
   logic signed [XW-1:0]    w_a1ll;

   logic                    r_s1_valid;
   logic [CH_W-1:0]         r_s1_ch;
   logic                    r_s1_bypass;
   logic [WIDTH-1:0]        r_s1_a1t;
   logic [WIDTH-1:0]        r_s1_a1ul;
   logic                    r_s1_gt;
   logic                    r_s1_lt;

   logic [WIDTH-1:0]        w_a1ll_lo;
   logic [WIDTH-1:0]        w_a1p;
   logic                    w_sat;

   logic                    r_out_valid;
   logic [CH_W-1:0]         r_out_ch;
   logic [WIDTH-1:0]        r_a1p;
   logic                    r_out_sat;

   logic [CNT_W-1:0]        r_cnt [CHANNELS];
   logic [CNT_W-1:0]        r_stat_cnt;
   logic                    w_inc;
   logic [CHANNELS-1:0]     w_inc_v;
   logic [CHANNELS-1:0]     w_clr_v;
   logic [CNT_W-1:0]        w_stat_rd;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   assign w_a1t_x = {{2{a1t[WIDTH-1]}}, a1t};
   assign w_a2p_x = {{2{a2p[WIDTH-1]}}, a2p};
   assign w_a1ul  = BOUND_X - w_a2p_x;
   assign w_a1ll  = -w_a1ul;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_ch     <= '0;
         r_s1_bypass <= 1'b0;
         r_s1_a1t    <= '0;
         r_s1_a1ul   <= '0;
         r_s1_gt     <= 1'b0;
         r_s1_lt     <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid  <= in_valid;
         r_s1_ch     <= in_ch;
         r_s1_bypass <= in_bypass;
         r_s1_a1t    <= a1t;
         r_s1_a1ul   <= w_a1ul[WIDTH-1:0];
         r_s1_gt     <= (w_a1t_x > w_a1ul);
         r_s1_lt     <= (w_a1t_x < w_a1ll);
      end
   end

   // Compares were done at full width in S1, so negating the truncated bound here is exact mod 2^WIDTH.
   assign w_a1ll_lo = -r_s1_a1ul;

   always_comb begin
      w_a1p = r_s1_a1t;
      w_sat = 1'b0;
      if (!r_s1_bypass) begin
         if (r_s1_gt) begin
            w_a1p = r_s1_a1ul;
            w_sat = 1'b1;
         end else if (r_s1_lt) begin
            w_a1p = w_a1ll_lo;
            w_sat = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_a1p       <= '0;
         r_out_sat   <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         r_out_ch    <= r_s1_ch;
         r_a1p       <= w_a1p;
         r_out_sat   <= w_sat;
      end
   end

   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign a1p       = r_a1p;
   assign out_sat   = r_out_sat;

   assign w_inc = r_out_valid && out_ready && r_out_sat;

   // Out-of-range channel indices never match any counter slot, so they neither count, clear nor read.
   always_comb begin
      w_inc_v   = '0;
      w_clr_v   = '0;
      w_stat_rd = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_inc_v[i] = w_inc && (r_out_ch == CH_W'(i));
         w_clr_v[i] = stat_clr && (stat_ch == CH_W'(i));
         if (stat_ch == CH_W'(i)) w_stat_rd = r_cnt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
         r_stat_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_clr_v[i])
               r_cnt[i] <= w_inc_v[i] ? CNT_W'(1) : '0;
            else if (w_inc_v[i] && (r_cnt[i] != '1))
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
         r_stat_cnt <= w_stat_rd;
      end
   end

   assign stat_cnt = r_stat_cnt;

endmodule

// File: tb/tb_limd_mc_pipe.sv
// Scoreboard bench for limd_mc_pipe: driver pushes hand-computed results, a negedge monitor pops and compares.
module tb_limd_mc_pipe;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_ch;
   logic        in_bypass;
   logic [15:0] a1t;
   logic [15:0] a2p;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_ch;
   logic [15:0] a1p;
   logic        out_sat;
   logic [4:0]  stat_ch;
   logic        stat_clr;
   logic [7:0]  stat_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  ch;
      logic [15:0] a1p;
      logic        sat;
   } exp_t;
   exp_t sb[$];

   limd_mc_pipe #(
      .WIDTH(16), .CHANNELS(32), .CH_W(5), .A1_BOUND(15360), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_bypass(in_bypass),
      .a1t(a1t), .a2p(a2p),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .a1p(a1p), .out_sat(out_sat),
      .stat_ch(stat_ch), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   logic        p_stall = 1'b0;
   logic [4:0]  p_ch;
   logic [15:0] p_a1p;
   logic        p_sat;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'({out_ch, a1p, out_sat}), int'({p_ch, p_a1p, p_sat}));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out actual=ch%0d/a1p%0d required=no_output", out_ch, $signed(a1p));
            end else begin
               e = sb.pop_front();
               chk("out_ch", int'(out_ch), int'(e.ch));
               chk("out_a1p", int'($signed(a1p)), int'($signed(e.a1p)));
               chk("out_sat", int'(out_sat), int'(e.sat));
            end
         end
         p_stall = out_valid && !out_ready;
         p_ch    = out_ch;
         p_a1p   = a1p;
         p_sat   = out_sat;
      end
   end

   task automatic send(input int ch, input int byp, input int a1t_v, input int a2p_v,
                       input int exp_a1p, input int exp_sat);
      int   n = 0;
      exp_t e;
      in_valid  = 1'b1;
      in_ch     = 5'(ch);
      in_bypass = byp[0];
      a1t       = 16'(a1t_v);
      a2p       = 16'(a2p_v);
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=in_ready0 required=in_ready1 ch=%0d", ch);
      end else begin
         e.ch  = 5'(ch);
         e.a1p = 16'(exp_a1p);
         e.sat = exp_sat[0];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic read_stat(input string name, input int ch, input int exp);
      stat_ch = 5'(ch);
      @(posedge clk);
      #1;
      chk(name, int'(stat_cnt), exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_bypass = 1'b0;
      a1t = '0; a2p = '0; out_ready = 1'b1; stat_ch = '0; stat_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_a1p", int'(a1p), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_stat_cnt", int'(stat_cnt), 0);
      @(posedge clk); #1;

      // Basic clamp and two-cycle latency.
      send(3, 0, 16000, 0, 15360, 1);
      @(negedge clk);
      chk("lat_cycle1", int'(out_valid), 0);
      @(negedge clk);
      chk("lat_cycle2", int'(out_valid), 1);
      @(posedge clk); #1;
      drain();
      read_stat("cnt_ch3", 3, 1);

      // Lower clamp, wide upper bound, boundary values.
      send(10, 0, -5000, 12288, -3072, 1);
      send(11, 0, 20000, -12288, 20000, 0);
      send(12, 0, 3072, 12288, 3072, 0);
      send(12, 0, -3072, 12288, -3072, 0);
      send(13, 0, 3073, 12288, 3072, 1);
      drain();
      read_stat("cnt_ch10", 10, 1);
      read_stat("cnt_ch11", 11, 0);
      read_stat("cnt_ch12", 12, 0);

      // Back-to-back stream with four stalled cycles.
      fork
         begin
            for (int i = 0; i < 10; i++) send(i, 0, 100 * i, 0, 100 * i, 0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_out_valid", int'(out_valid), 1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Counter saturation, then clear coincident with an increment.
      for (int i = 0; i < 300; i++) send(31, 0, 16000, 0, 15360, 1);
      drain();
      read_stat("cnt_ch31_sat", 31, 255);
      out_ready = 1'b0;
      send(31, 0, -16000, 0, -15360, 1);
      @(posedge clk); #1;
      chk("clr_setup_valid", int'(out_valid), 1);
      stat_ch = 5'd31; stat_clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      read_stat("cnt_ch31_clr_inc", 31, 1);

      // Bypass: large a1t passes unchanged and the counter is untouched.
      send(3, 1, 30000, 0, 30000, 0);
      drain();
      read_stat("cnt_ch3_bypass", 3, 1);

      // Mid-flight reset with two samples held in the pipe.
      out_ready = 1'b0;
      send(7, 0, 16000, 0, 15360, 1);
      send(8, 0, 16000, 0, 15360, 1);
      reset = 1'b1;
      sb.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_out_valid", int'(out_valid), 0);
      chk("rst2_in_ready", int'(in_ready), 1);
      for (int c = 0; c < 32; c++) read_stat($sformatf("rst2_cnt_ch%0d", c), c, 0);
      repeat (5) @(posedge clk); #1;
      send(2, 0, -20000, 0, -15360, 1);
      drain();
      read_stat("cnt_ch2_after_rst", 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/limd_mc_pipe.md
Name: limd_mc_pipe

Overview:
- Multi-channel, pipelined successor to the single-sample LIMD (a1 predictor-coefficient limiter) in the ADPCM datapath.
- Accepts time-multiplexed {channel, A1T, A2P} samples over a valid/ready handshake.
- Clamps A1T to ±(A1_BOUND − A2P) and emits A1P tagged with its channel.
- Keeps a per-channel saturation-event counter for the MCAC controller to read and clear.

Parameters:
- WIDTH, 16, two's-complement width of A1T, A2P and A1P
- CHANNELS, 32, number of channels (≥2)
- CH_W, 5, channel-index width (≥ clog2(CHANNELS))
- A1_BOUND, 15360, base limit constant (G.726 value)
- CNT_W, 8, width of each per-channel saturation counter

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_ch  in  CH_W  channel of the input sample
- in_bypass  in  1  pass A1T unlimited for this sample
- a1t  in  WIDTH  unlimited a1 coefficient, signed
- a2p  in  WIDTH  limited a2 coefficient, signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output sample
- out_ch  out  CH_W  channel tag of the output sample
- a1p  out  WIDTH  limited a1 coefficient, signed
- out_sat  out  1  sample was clamped
- stat_ch  in  CH_W  channel selected for counter read/clear
- stat_clr  in  1  clear counter[stat_ch] (single-cycle pulse)
- stat_cnt  out  CNT_W  counter[stat_ch], registered

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_ch=0, a1p=0, out_sat=0, stat_cnt=0.
  - All pipeline valids and all CHANNELS counters cleared.
  - in_ready=1 from the first cycle after reset.
  - reset asserted mid-operation discards all in-flight samples; no output handshake occurs for them.
- Arithmetic, at WIDTH+2 bits with sign extension:
  - A1UL = A1_BOUND − a2p; A1LL = −A1UL.
  - If a1t > A1UL: a1p=A1UL, sat=1.
  - Else if a1t < A1LL: a1p=A1LL, sat=1.
  - Else: a1p=a1t, sat=0.
  - a1t exactly equal to a bound is not saturation.
  - The result is truncated to WIDTH bits. In-range operands (|a2p| ≤ 12288) never overflow; out-of-range operands wrap modulo 2^WIDTH, with no error signalled.
  - in_bypass=1: a1p=a1t, sat=0, counter untouched.
- Pipeline structure: 2 stages.
  - S1 registers ch, bypass, a1t, A1UL, and the two compare results.
  - S2 registers the selected a1p, out_sat and out_ch, and drives out_valid.
- Handshake and flow:
  - A sample is accepted when in_valid & in_ready; it is produced when out_valid & out_ready.
  - Latency is 2 cycles from accept to out_valid with no backpressure.
  - Throughput is 1 sample/cycle.
  - Pipeline advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational from out_ready only).
  - On adv=0, both stages hold every register; out_* stay stable while out_valid=1 & out_ready=0.
  - Bubbles (in_valid=0 on an accept slot) propagate as invalid stages. out_valid never asserts for a bubble.
  - in_ch ≥ CHANNELS: the sample is processed normally; its counter is not updated.
- Counters:
  - counter[out_ch] increments on an output handshake with out_sat=1.
  - Counters saturate at 2^CNT_W−1 (no wrap).
  - stat_cnt is registered from counter[stat_ch] one cycle after stat_ch is presented, sampling the pre-update value.
  - stat_clr=1 zeroes counter[stat_ch].
  - Simultaneous clear and increment on the same channel: the result is 1.
  - Simultaneous clear and increment on different channels: both take effect.
  - stat_ch ≥ CHANNELS: stat_cnt reads 0 and the clear is ignored.

Test Plan:
- a2p=0, a1t=16000, one sample on ch 3:
  - out_valid asserts 2 cycles later with a1p=15360, out_sat=1, out_ch=3.
  - Reading stat_ch=3 gives stat_cnt=1.
- a2p=12288, a1t=−5000 → a1p=−3072, sat=1. Then a2p=−12288, a1t=20000 → a1p=20000, sat=0 (A1UL=27648). Then a1t=3072, a2p=12288 → a1p=3072, sat=0 (boundary).
- Back-to-back stream of 10 samples on ch 0..9, with out_ready held 0 for cycles 4–7:
  - in_ready=0 while the pipe is full.
  - Outputs hold stable while stalled.
  - All 10 samples emerge in order, none lost or duplicated.
- 300 saturating samples on ch 31 → stat_cnt=255. Then stat_clr on ch 31 coincident with a saturating output on ch 31 → stat_cnt=1 on the following read.
- in_bypass=1, a1t=30000, a2p=0 → a1p=30000, sat=0, counter unchanged.
- reset asserted for 1 cycle with 2 samples in flight:
  - Next cycle: out_valid=0, in_ready=1, and all counters read 0.
  - No stale output ever appears.
